combi_isa_mode_tracker: RTL and testbench
=========================================

Name: combi_isa_mode_tracker

Overview:
Sequential ISA-mode tracker for the combined ARM/RISC-V decode stage. It replaces the per-instruction combinational mode pick with a registered mode and hysteresis. A mode switch requires SWITCH_THRESH consecutive unambiguous instructions of the other ISA. On a switch the block requests a replay of the mis-decoded instructions, and it raises a sticky trap after repeated undecodable instructions.

Parameters:
SWITCH_THRESH, 2, consecutive other-ISA-only instructions needed to switch mode (1..2^CNT_W-1)
ILLEGAL_LIMIT, 4, consecutive neither-valid instructions that set TrapD (1..2^CNT_W-1)
CNT_W, 3, width of the probe and illegal counters
RESET_ARM, 0, mode after reset (1 = ARM, 0 = RISC-V)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
StallD  input  1  decode stage stalled; no state update
FlushD  input  1  decode instruction is a bubble; no classification
RV_validD  input  1  RISC-V main and ALU decoders both accept the instruction
ARM_validD  input  1  ARM main and ALU decoders both accept the instruction
armD  output  1  current mode (1 = ARM) used to select decoder outputs; driven from the mode register
ModeSwitchD  output  1  one-cycle pulse: mode changed at the last edge
ReplayD  output  1  one-cycle pulse coincident with ModeSwitchD: refetch the last ReplayCntD instructions
ReplayCntD  output  CNT_W  number of instructions to refetch; equals SWITCH_THRESH while ReplayD is high, else 0
IllegalD  output  1  one-cycle pulse: previous accepted instruction was neither-valid
TrapD  output  1  sticky; set when the illegal counter reaches ILLEGAL_LIMIT
ProbeCntD  output  CNT_W  debug: current probe count

Behaviour:
- Clock and reset: one clock domain, clk. Reset is synchronous and active-high.
- Reset values: mode = RESET_ARM; state = RESET_ARM ? ARM : RV; probe_cnt = 0; ill_cnt = 0. ModeSwitchD, ReplayD, IllegalD and TrapD are 0; ReplayCntD = 0.
- Reset wins over all other inputs, including mid-probe. An in-progress probe is discarded.
- Accepted instruction: acc = !StallD & !FlushD.
  - When acc = 0, all state and counters hold and all pulses deassert.
  - StallD together with FlushD is treated as stall.
- Classification of each accepted instruction:
  - BOTH = RV & ARM
  - ARM_ONLY = ARM & !RV
  - RV_ONLY = RV & !ARM
  - NEITHER = !RV & !ARM
- FSM states: ARM, RV, PROBE_RV (mode ARM, counting RV_ONLY), PROBE_ARM (mode RV, counting ARM_ONLY).
- ARM state:
  - ARM_ONLY or BOTH: stay.
  - RV_ONLY: if SWITCH_THRESH == 1, switch immediately. Otherwise go to PROBE_RV with probe_cnt = 1.
- PROBE_RV state:
  - RV_ONLY: probe_cnt + 1. When that value equals SWITCH_THRESH, perform a switch.
  - ARM_ONLY: return to ARM with probe_cnt = 0.
  - BOTH or NEITHER: state and probe_cnt hold.
- RV and PROBE_ARM: symmetric to ARM and PROBE_RV with the ISAs swapped.
- Switch action, at the edge:
  - mode toggles, state becomes the new stable state, probe_cnt = 0.
  - The next cycle has ModeSwitchD = 1, ReplayD = 1 and ReplayCntD = SWITCH_THRESH.
  - armD reflects the new mode in that same cycle.
- Mode timing: armD never changes mid-cycle and is never X. During a probe, armD keeps the old mode.
- Illegal counter:
  - NEITHER: ill_cnt increments, saturating at ILLEGAL_LIMIT, and IllegalD pulses the next cycle.
  - Any other accepted class clears ill_cnt.
  - Non-accepted cycles leave ill_cnt unchanged, so stalls and flushes do not break a run.
- Trap: when ill_cnt reaches ILLEGAL_LIMIT, TrapD is set next edge and stays set until reset. TrapD does not freeze mode tracking.
- Latency: every output is a function of registered state only; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset with RESET_ARM=0, then 5 accepted RV_ONLY instructions -> armD=0 throughout; ModeSwitchD, ReplayD and IllegalD stay 0; ProbeCntD=0.
- Defaults, mode RV: ARM_ONLY, ARM_ONLY -> ProbeCntD reads 1 after the first; after the second edge armD=1, ModeSwitchD=1, ReplayD=1, ReplayCntD=2 for exactly one cycle, then ReplayCntD=0.
- Mode RV: ARM_ONLY, BOTH, StallD cycle, FlushD cycle, RV_ONLY -> ProbeCntD holds 1 through BOTH, stall and flush; returns to 0 on RV_ONLY; armD stays 0; no switch.
- SWITCH_THRESH=1, mode ARM: single RV_ONLY -> armD=0 next cycle, ModeSwitchD=1, ReplayCntD=1.
- Defaults: 3 NEITHER, one StallD cycle, 1 NEITHER -> IllegalD pulses 4 times; TrapD=1 after the 4th and stays 1 after subsequent RV_ONLY instructions; a 3-NEITHER run followed by BOTH leaves TrapD=0.
- Mode RV: ARM_ONLY, then reset asserted with ARM_ONLY on inputs -> ProbeCntD=0, armD=RESET_ARM, no ModeSwitchD pulse; the next ARM_ONLY only restarts the probe at 1.

Source files
------------

// File: rtl/combi_isa_mode_tracker_if.sv
// Decode-stage ISA-mode tracker bus.
// Carries the per-instruction decode qualifiers into the tracker and the
// registered mode / replay / trap indications back out to the decode stage.
//   StallD, FlushD          : decode stage stalled / bubble
//   RV_validD, ARM_validD   : decoder acceptance flags for the current instruction
//   armD                    : registered current mode (1 = ARM)
//   ModeSwitchD, ReplayD    : one-cycle pulses after a mode switch
//   ReplayCntD              : instructions to refetch while ReplayD is high
//   IllegalD, TrapD         : illegal-instruction pulse and sticky trap
//   ProbeCntD, state_dbg    : debug view of probe counter and FSM state
//
// Handshake: there is no valid/ready pair. An instruction is consumed by the
// tracker on a rising clk edge exactly when StallD == 0 and FlushD == 0; any
// other cycle is a hold cycle in which the tracker's state does not move.
interface combi_isa_mode_tracker_if #(
    parameter int CNT_W = 3
);
    logic             StallD;
    logic             FlushD;
    logic             RV_validD;
    logic             ARM_validD;
    logic             armD;
    logic             ModeSwitchD;
    logic             ReplayD;
    logic [CNT_W-1:0] ReplayCntD;
    logic             IllegalD;
    logic             TrapD;
    logic [CNT_W-1:0] ProbeCntD;
    logic [1:0]       state_dbg;

    modport master (
        output StallD, FlushD, RV_validD, ARM_validD,
        input  armD, ModeSwitchD, ReplayD, ReplayCntD, IllegalD, TrapD,
               ProbeCntD, state_dbg
    );

    modport slave (
        input  StallD, FlushD, RV_validD, ARM_validD,
        output armD, ModeSwitchD, ReplayD, ReplayCntD, IllegalD, TrapD,
               ProbeCntD, state_dbg
    );
endinterface

// File: rtl/combi_isa_mode_tracker.sv
// Registered ISA-mode tracker with hysteresis for the combined ARM/RISC-V
// decode stage. A mode switch needs SWITCH_THRESH consecutive instructions
// that only the other ISA accepts; a switch requests a replay of those
// instructions. Runs of instructions accepted by neither decoder pulse
// IllegalD and eventually set the sticky TrapD.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : combi_isa_mode_tracker_if slave modport (see interface header)
// All outputs come straight from registers (ReplayCntD is a constant gated by
// a register), so there is no input-to-output combinational path.
module combi_isa_mode_tracker #(
    parameter int SWITCH_THRESH = 2,
    parameter int ILLEGAL_LIMIT = 4,
    parameter int CNT_W         = 3,
    parameter bit RESET_ARM     = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    combi_isa_mode_tracker_if.slave       bus
);
    typedef enum logic [1:0] {
        S_RV        = 2'd0,
        S_ARM       = 2'd1,
        S_PROBE_RV  = 2'd2,   // mode ARM, counting RV-only instructions
        S_PROBE_ARM = 2'd3    // mode RV, counting ARM-only instructions
    } state_t;

    localparam logic [CNT_W-1:0] THR_C = CNT_W'(SWITCH_THRESH);
    localparam logic [CNT_W-1:0] ILL_C = CNT_W'(ILLEGAL_LIMIT);

    state_t           state_q;
    logic             mode_q;
    logic [CNT_W-1:0] probe_q;
    logic [CNT_W-1:0] ill_q;
    logic             switch_q;
    logic             illegal_q;
    logic             trap_q;

    logic             acc;
    logic             rv_only;
    logic             arm_only;
    logic             neither;
    logic [CNT_W-1:0] probe_inc;
    logic [CNT_W-1:0] ill_inc;

    always_comb begin
        acc       = !bus.StallD && !bus.FlushD;
        rv_only   = bus.RV_validD && !bus.ARM_validD;
        arm_only  = bus.ARM_validD && !bus.RV_validD;
        neither   = !bus.RV_validD && !bus.ARM_validD;
        probe_inc = probe_q + 1'b1;
        ill_inc   = ill_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_ARM ? S_ARM : S_RV;
            mode_q    <= RESET_ARM;
            probe_q   <= '0;
            ill_q     <= '0;
            switch_q  <= 1'b0;
            illegal_q <= 1'b0;
            trap_q    <= 1'b0;
        end else begin
            switch_q  <= 1'b0;
            illegal_q <= 1'b0;
            if (acc) begin
                // Illegal-run counter saturates at the limit; the trap is
                // taken on the same edge the counter lands on the limit.
                if (neither) begin
                    illegal_q <= 1'b1;
                    if (ill_q != ILL_C) ill_q <= ill_inc;
                    if (ill_q == ILL_C || ill_inc == ILL_C) trap_q <= 1'b1;
                end else begin
                    ill_q <= '0;
                end

                case (state_q)
                    S_ARM: begin
                        if (rv_only) begin
                            if (SWITCH_THRESH == 1) begin
                                state_q  <= S_RV;
                                mode_q   <= 1'b0;
                                probe_q  <= '0;
                                switch_q <= 1'b1;
                            end else begin
                                state_q <= S_PROBE_RV;
                                probe_q <= CNT_W'(1);
                            end
                        end
                    end
                    S_PROBE_RV: begin
                        if (rv_only) begin
                            if (probe_inc == THR_C) begin
                                state_q  <= S_RV;
                                mode_q   <= 1'b0;
                                probe_q  <= '0;
                                switch_q <= 1'b1;
                            end else begin
                                probe_q <= probe_inc;
                            end
                        end else if (arm_only) begin
                            state_q <= S_ARM;
                            probe_q <= '0;
                        end
                    end
                    S_RV: begin
                        if (arm_only) begin
                            if (SWITCH_THRESH == 1) begin
                                state_q  <= S_ARM;
                                mode_q   <= 1'b1;
                                probe_q  <= '0;
                                switch_q <= 1'b1;
                            end else begin
                                state_q <= S_PROBE_ARM;
                                probe_q <= CNT_W'(1);
                            end
                        end
                    end
                    S_PROBE_ARM: begin
                        if (arm_only) begin
                            if (probe_inc == THR_C) begin
                                state_q  <= S_ARM;
                                mode_q   <= 1'b1;
                                probe_q  <= '0;
                                switch_q <= 1'b1;
                            end else begin
                                probe_q <= probe_inc;
                            end
                        end else if (rv_only) begin
                            state_q <= S_RV;
                            probe_q <= '0;
                        end
                    end
                    default: begin
                        state_q <= mode_q ? S_ARM : S_RV;
                        probe_q <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.armD        = mode_q;
    assign bus.ModeSwitchD = switch_q;
    assign bus.ReplayD     = switch_q;
    assign bus.ReplayCntD  = switch_q ? THR_C : '0;
    assign bus.IllegalD    = illegal_q;
    assign bus.TrapD       = trap_q;
    assign bus.ProbeCntD   = probe_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_combi_isa_mode_tracker.sv
module tb_combi_isa_mode_tracker;
    localparam int CNT_W = 3;
    localparam int W     = 11;
    localparam int LIMIT = 4;

    logic clk;
    logic reset;

    combi_isa_mode_tracker_if #(.CNT_W(CNT_W)) bus0 ();
    combi_isa_mode_tracker_if #(.CNT_W(CNT_W)) bus1 ();

    // Default instance: threshold 2, starts in RISC-V mode.
    combi_isa_mode_tracker #(
        .SWITCH_THRESH(2), .ILLEGAL_LIMIT(LIMIT), .CNT_W(CNT_W), .RESET_ARM(1'b0)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus0)
    );

    // Immediate-switch instance: threshold 1, starts in ARM mode.
    combi_isa_mode_tracker #(
        .SWITCH_THRESH(1), .ILLEGAL_LIMIT(LIMIT), .CNT_W(CNT_W), .RESET_ARM(1'b1)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Per instance: current mode, length of the current run of other-ISA-only
    // instructions, length of the current illegal run, sticky trap and the
    // pulses produced by the last accepted instruction.
    int thr   [2] = '{2, 1};
    bit rarm  [2] = '{1'b0, 1'b1};
    bit m_mode[2];
    int m_run [2];
    int m_ill [2];
    bit m_trap[2];
    bit m_sw  [2];
    bit m_il  [2];

    logic [W-1:0] exp_q[$];
    int n_tests;
    int n_fail;

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k] = rarm[k];
            m_run[k]  = 0;
            m_ill[k]  = 0;
            m_trap[k] = 1'b0;
            m_sw[k]   = 1'b0;
            m_il[k]   = 1'b0;
        end
    endtask

    task automatic model_step(int k, bit acc, bit rv, bit ar);
        bit other_only;
        bit own_only;
        m_sw[k] = 1'b0;
        m_il[k] = 1'b0;
        if (!acc) return;
        other_only = m_mode[k] ? (rv && !ar) : (ar && !rv);
        own_only   = m_mode[k] ? (ar && !rv) : (rv && !ar);
        if (other_only) begin
            m_run[k] = m_run[k] + 1;
            if (m_run[k] == thr[k]) begin
                m_mode[k] = !m_mode[k];
                m_run[k]  = 0;
                m_sw[k]   = 1'b1;
            end
        end else if (own_only) begin
            m_run[k] = 0;
        end
        if (!rv && !ar) begin
            m_il[k]  = 1'b1;
            m_ill[k] = (m_ill[k] < LIMIT) ? m_ill[k] + 1 : LIMIT;
            if (m_ill[k] == LIMIT) m_trap[k] = 1'b1;
        end else begin
            m_ill[k] = 0;
        end
    endtask

    function automatic logic [W-1:0] pack_exp(int k);
        logic [CNT_W-1:0] rc;
        logic [CNT_W-1:0] pc;
        rc = m_sw[k] ? CNT_W'(thr[k]) : '0;
        pc = CNT_W'(m_run[k]);
        return {m_mode[k], m_sw[k], m_sw[k], rc, m_il[k], m_trap[k], pc};
    endfunction

    // ---------------- checking ----------------
    task automatic chk(string tag, int obs, int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(string ctx);
        logic [W-1:0] e;
        exp_q.push_back(pack_exp(0));
        exp_q.push_back(pack_exp(1));

        e = exp_q.pop_front();
        chk({ctx, ".d0.armD"},        int'(bus0.armD),        int'(e[10]));
        chk({ctx, ".d0.ModeSwitchD"}, int'(bus0.ModeSwitchD), int'(e[9]));
        chk({ctx, ".d0.ReplayD"},     int'(bus0.ReplayD),     int'(e[8]));
        chk({ctx, ".d0.ReplayCntD"},  int'(bus0.ReplayCntD),  int'(e[7:5]));
        chk({ctx, ".d0.IllegalD"},    int'(bus0.IllegalD),    int'(e[4]));
        chk({ctx, ".d0.TrapD"},       int'(bus0.TrapD),       int'(e[3]));
        chk({ctx, ".d0.ProbeCntD"},   int'(bus0.ProbeCntD),   int'(e[2:0]));

        e = exp_q.pop_front();
        chk({ctx, ".d1.armD"},        int'(bus1.armD),        int'(e[10]));
        chk({ctx, ".d1.ModeSwitchD"}, int'(bus1.ModeSwitchD), int'(e[9]));
        chk({ctx, ".d1.ReplayD"},     int'(bus1.ReplayD),     int'(e[8]));
        chk({ctx, ".d1.ReplayCntD"},  int'(bus1.ReplayCntD),  int'(e[7:5]));
        chk({ctx, ".d1.IllegalD"},    int'(bus1.IllegalD),    int'(e[4]));
        chk({ctx, ".d1.TrapD"},       int'(bus1.TrapD),       int'(e[3]));
        chk({ctx, ".d1.ProbeCntD"},   int'(bus1.ProbeCntD),   int'(e[2:0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(bit st, bit fl, bit rv, bit ar);
        bus0.StallD = st; bus0.FlushD = fl; bus0.RV_validD = rv; bus0.ARM_validD = ar;
        bus1.StallD = st; bus1.FlushD = fl; bus1.RV_validD = rv; bus1.ARM_validD = ar;
    endtask

    task automatic step(bit st, bit fl, bit rv, bit ar, string ctx);
        drive(st, fl, rv, ar);
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k, !st && !fl, rv, ar);
        #1;
        check_all(ctx);
    endtask

    task automatic do_reset(bit st, bit fl, bit rv, bit ar, string ctx);
        drive(st, fl, rv, ar);
        reset = 1'b1;
        @(posedge clk);
        model_reset();
        #1;
        check_all(ctx);
        reset = 1'b0;
    endtask

    // Instruction classes as {rv, arm}
    localparam bit [1:0] RVO = 2'b10;
    localparam bit [1:0] ARO = 2'b01;
    localparam bit [1:0] BTH = 2'b11;
    localparam bit [1:0] NTH = 2'b00;

    task automatic inst(bit [1:0] c, string ctx);
        step(1'b0, 1'b0, c[1], c[0], ctx);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();

        // Idle in own mode
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, "rst0");
        for (int i = 0; i < 5; i++) inst(RVO, "rv_idle");

        // Two ARM-only switch RISC-V -> ARM, then pulses drop
        inst(ARO, "sw_a1");
        inst(ARO, "sw_a2");
        inst(RVO, "post_sw");
        inst(ARO, "post_sw2");

        // Probe holds across BOTH / stall / flush, cleared by own ISA
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, "rst1");
        inst(ARO, "hold_a");
        inst(BTH, "hold_both");
        step(1'b1, 1'b0, 1'b0, 1'b1, "hold_stall");
        step(1'b0, 1'b1, 1'b0, 1'b1, "hold_flush");
        step(1'b1, 1'b1, 1'b0, 1'b1, "hold_stfl");
        inst(RVO, "hold_clear");

        // Illegal run with a stall in the middle reaches the trap
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, "rst2");
        for (int i = 0; i < 3; i++) inst(NTH, "ill_run");
        step(1'b1, 1'b0, 1'b0, 1'b0, "ill_stall");
        inst(NTH, "ill_4th");
        inst(NTH, "ill_sat");
        inst(RVO, "trap_sticky1");
        inst(RVO, "trap_sticky2");
        inst(ARO, "trap_track1");
        inst(ARO, "trap_track2");

        // Short illegal run broken by BOTH never traps
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, "rst3");
        for (int i = 0; i < 3; i++) inst(NTH, "ill3");
        inst(BTH, "ill_break");
        for (int i = 0; i < 3; i++) inst(NTH, "ill3b");

        // Reset mid-probe discards the probe
        do_reset(1'b0, 1'b0, 1'b0, 1'b0, "rst4");
        inst(ARO, "mid_probe");
        do_reset(1'b0, 1'b0, 1'b0, 1'b1, "rst_mid");
        inst(ARO, "probe_restart");
        inst(ARO, "probe_switch");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int  cls;
            bit  st;
            bit  fl;
            bit [1:0] c;
            st  = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            cls = $urandom_range(0, 9);
            if (cls < 4)       c = RVO;
            else if (cls < 8)  c = ARO;
            else if (cls == 8) c = BTH;
            else               c = NTH;
            if ($urandom_range(0, 59) == 0)
                do_reset(st, fl, c[1], c[0], "rnd_rst");
            else
                step(st, fl, c[1], c[0], "rnd");
        end

        // Long illegal runs in random mode context
        for (int i = 0; i < 40; i++) begin
            bit [1:0] c;
            c = ($urandom_range(0, 3) == 0) ? BTH : NTH;
            step($urandom_range(0, 4) == 0, 1'b0, c[1], c[0], "rnd_ill");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
